// File: rtl/marmot_wb_ram_reader.sv
// Wishbone read-only window onto a bank of single-port SRAM read ports.
// Optional read-statistics counter is enabled with `define MARMOT_RAMDBG_STATS_EN.
module marmot_wb_ram_reader #(
    parameter int         NBANKS  = 8,
    parameter int         AW      = 9,
    parameter int         DW      = 32,
    parameter int         RD_LAT  = 1,
    parameter logic [7:0] BASE_HI = 8'h30
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NBANKS-1:0]      ram_csb1,
    output logic [AW-1:0]          ram_addr1,
    input  logic [NBANKS*DW-1:0]   ram_rdata1
);

    localparam int LW  = $clog2(DW / 32);
    localparam int BW  = $clog2(NBANKS);
    localparam int LWS = (LW > 0) ? LW : 1;
    localparam int BWS = (BW > 0) ? BW : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t            state_q;
    logic [NBANKS-1:0] csb_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       data_q;
    logic [BWS-1:0]    bank_q;
    logic [LWS-1:0]    lane_q;
    logic [2:0]        cnt_q;
    logic              ram_rd_q;

    logic [31:0]    lane_sh, word_sh, bank_sh;
    logic [LWS-1:0] req_lane;
    logic [AW-1:0]  req_word;
    logic [BWS-1:0] req_bank;
    logic           req_reg_sel;
    logic           hit;
    logic [31:0]    rd_word;
    logic [31:0]    stats_word;
    int             rd_base;

    // Shift-then-truncate keeps zero-width fields (single bank, 32-bit lanes) legal.
    assign lane_sh     = wbs_adr_i >> 2;
    assign word_sh     = wbs_adr_i >> (2 + LW);
    assign bank_sh     = wbs_adr_i >> (2 + LW + AW);
    assign req_lane    = (LW > 0) ? lane_sh[LWS-1:0] : '0;
    assign req_word    = word_sh[AW-1:0];
    assign req_bank    = (BW > 0) ? bank_sh[BWS-1:0] : '0;
    assign req_reg_sel = wbs_adr_i[23];
    assign hit         = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE_HI);

    always_comb begin
        rd_base = int'(bank_q) * DW + int'(lane_q) * 32;
        rd_word = 32'(ram_rdata1 >> rd_base);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            csb_q    <= '1;
            addr_q   <= '0;
            data_q   <= '0;
            bank_q   <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            ram_rd_q <= 1'b0;
        end else begin
            csb_q <= '1;
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        if (!wbs_we_i && !req_reg_sel) begin
                            bank_q   <= req_bank;
                            lane_q   <= req_lane;
                            addr_q   <= req_word;
                            csb_q    <= ~(NBANKS'(1) << req_bank);
                            ram_rd_q <= 1'b1;
                            state_q  <= S_ISSUE;
                        end else begin
                            ram_rd_q <= 1'b0;
                            data_q   <= wbs_we_i ? 32'h0 : stats_word;
                            state_q  <= S_ACK;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= 3'(RD_LAT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        data_q  <= rd_word;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MARMOT_RAMDBG_STATS_EN
    logic [31:0] stats_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stats_q <= '0;
        end else if (state_q == S_ACK && ram_rd_q) begin
            stats_q <= stats_q + 32'd1;
        end
    end

    assign stats_word = stats_q;
`else
    assign stats_word = 32'h0;
`endif

    // A master that drops cyc before the ack cycle gets no ack at all.
    assign wbs_ack_o = (state_q == S_ACK) & wbs_cyc_i;
    assign wbs_dat_o = wbs_ack_o ? data_q : 32'h0;
    assign ram_csb1  = csb_q;
    assign ram_addr1 = addr_q;

    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0], lane_sh, word_sh, bank_sh};

endmodule

// File: tb/tb_marmot_wb_ram_reader.sv
// Bench for marmot_wb_ram_reader: two instances (32-bit/RD_LAT=1 and 64-bit/RD_LAT=3)
// driven by directed and random Wishbone traffic, with SRAM and address-decode models.
module tb_marmot_wb_ram_reader;

    logic        clk;
    logic        rst;
    logic        stb_a, stb_b, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;

    logic        ack_a, ack_b;
    logic [31:0] dat_a, dat_b;
    logic [7:0]  csb_a;
    logic [3:0]  csb_b;
    logic [7:0]  addr_a;
    logic [8:0]  addr_b;
    logic [255:0] rdata_a, rdata_b, pipe_b0, pipe_b1;

    logic [31:0] mem_a [8][256];
    logic [63:0] mem_b [4][512];

    int vectors = 0;
    int miscompares = 0;
    int stats_a = 0;

    marmot_wb_ram_reader #(.NBANKS(8), .AW(8), .DW(32), .RD_LAT(1), .BASE_HI(8'h30)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb_a), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
        .ram_csb1(csb_a), .ram_addr1(addr_a), .ram_rdata1(rdata_a)
    );

    marmot_wb_ram_reader #(.NBANKS(4), .AW(9), .DW(64), .RD_LAT(3), .BASE_HI(8'h30)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb_b), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
        .ram_csb1(csb_b), .ram_addr1(addr_b), .ram_rdata1(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data valid for exactly one cycle RD_LAT clocks after select, garbage otherwise.
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            rdata_a[b*32 +: 32] <= (!csb_a[b]) ? mem_a[b][addr_a] : $urandom;
        for (int b = 0; b < 4; b++)
            pipe_b0[b*64 +: 64] <= (!csb_b[b]) ? mem_b[b][addr_b] : {$urandom, $urandom};
        pipe_b1 <= pipe_b0;
        rdata_b <= pipe_b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stats();
`ifdef MARMOT_RAMDBG_STATS_EN
        return 32'(stats_a);
`else
        return 32'h0;
`endif
    endfunction

    function automatic int bank_of(input bit sel_b, input logic [31:0] a);
        return sel_b ? int'((a >> 12) % 4) : int'((a >> 10) % 8);
    endfunction

    function automatic int word_of(input bit sel_b, input logic [31:0] a);
        return sel_b ? int'((a >> 3) % 512) : int'((a >> 2) % 256);
    endfunction

    function automatic logic [31:0] ref_data(input bit sel_b, input logic [31:0] a);
        logic [63:0] w;
        if (sel_b) begin
            w = mem_b[bank_of(1, a)][word_of(1, a)];
            return 32'(w >> (32 * ((a >> 2) % 2)));
        end
        return mem_a[bank_of(0, a)][word_of(0, a)];
    endfunction

    // One Wishbone transaction; inputs change 1 time unit after a rising edge.
    task automatic xact(input bit sel_b, input logic [31:0] a, input bit w, input bit exp_ack,
                        input int exp_n, input logic [31:0] exp_dat, input bit rd_ram, input string tag);
        int ack_n;
        int lim;
        logic [15:0] mask, o_csb, o_addr;
        logic        o_ack;
        logic [31:0] o_dat;
        mask = sel_b ? 16'h000F : 16'h00FF;
        adr = a; we = w; dat_i = $urandom; sel = 4'($urandom); cyc = 1'b1;
        if (sel_b) stb_b = 1'b1; else stb_a = 1'b1;
        ack_n = 0;
        lim = exp_ack ? exp_n + 4 : 10;
        for (int n = 1; n <= lim && ack_n == 0; n++) begin
            @(posedge clk); #1;
            o_csb  = sel_b ? 16'(csb_b) : 16'(csb_a);
            o_addr = sel_b ? 16'(addr_b) : 16'(addr_a);
            o_ack  = sel_b ? ack_b : ack_a;
            o_dat  = sel_b ? dat_b : dat_a;
            if (rd_ram && n == 1) begin
                chk({tag, "_csb_issue"}, 64'(o_csb), 64'(mask & ~(16'd1 << bank_of(sel_b, a))));
                chk({tag, "_addr_issue"}, 64'(o_addr), 64'(word_of(sel_b, a)));
            end else begin
                chk({tag, "_csb_idle"}, 64'(o_csb), 64'(mask));
            end
            if (o_ack) begin
                ack_n = n;
                chk({tag, "_dat"}, 64'(o_dat), 64'(exp_dat));
            end else begin
                chk({tag, "_dat_noack"}, 64'(o_dat), 64'h0);
            end
        end
        chk({tag, "_ack_cycle"}, 64'(ack_n), exp_ack ? 64'(exp_n) : 64'h0);
        if (ack_n != 0) begin
            @(posedge clk); #1;
        end
        stb_a = 1'b0; stb_b = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!sel_b && rd_ram && ack_n != 0) stats_a++;
        $display("xact %s inst=%s adr=%08h we=%0d ack_cycle=%0d exp_dat=%08h",
                 tag, sel_b ? "B" : "A", a, w, ack_n, exp_dat);
    endtask

    task automatic rand_ram_read(input bit sel_b, input string tag);
        logic [31:0] a;
        a = 32'h3000_0000 | ($urandom & 32'h007F_FFFF);
        xact(sel_b, a, 1'b0, 1'b1, sel_b ? 5 : 3, ref_data(sel_b, a), 1'b1, tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  hb;
        int          r;
        rst = 1'b1; stb_a = 1'b0; stb_b = 1'b0; cyc = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0;
        for (int b = 0; b < 8; b++)
            for (int w = 0; w < 256; w++) mem_a[b][w] = $urandom;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 512; w++) mem_b[b][w] = {$urandom, $urandom};
        mem_a[3][4] = 32'hA5A5_1234;
        mem_b[2][7] = 64'h1111_2222_3333_4444;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack_a", 64'(ack_a), 64'h0);
        chk("rst_dat_a", 64'(dat_a), 64'h0);
        chk("rst_csb_a", 64'(csb_a), 64'hFF);
        chk("rst_addr_a", 64'(addr_a), 64'h0);
        chk("rst_csb_b", 64'(csb_b), 64'hF);
        chk("rst_addr_b", 64'(addr_b), 64'h0);

        xact(1'b0, 32'h3000_0C10, 1'b0, 1'b1, 3, 32'hA5A5_1234, 1'b1, "read_b3w4");
        xact(1'b0, 32'h3000_0000, 1'b1, 1'b1, 1, 32'h0, 1'b0, "write_ack");
        xact(1'b0, 32'h4000_0000, 1'b0, 1'b0, 0, 32'h0, 1'b0, "miss_base");
        xact(1'b1, 32'h3000_203C, 1'b0, 1'b1, 5, 32'h1111_2222, 1'b1, "dw64_lane1");

        // Reset pulse while instance B sits in its wait phase.
        adr = 32'h3000_1008; we = 1'b0; cyc = 1'b1; stb_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; stb_b = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        stats_a = 0;
        chk("abort_csb_b", 64'(csb_b), 64'hF);
        chk("abort_ack_b", 64'(ack_b), 64'h0);
        chk("abort_addr_b", 64'(addr_b), 64'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_noack_b", 64'(ack_b), 64'h0);
        end
        rand_ram_read(1'b1, "after_abort");

        for (int i = 0; i < 3; i++) rand_ram_read(1'b0, "stats_read");
        xact(1'b0, 32'h3080_0000, 1'b0, 1'b1, 1, exp_stats(), 1'b0, "stats_reg");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = 32'h3000_0000 | $urandom;
                a[31:24] = 8'h30;
                xact(i[0], a, 1'b1, 1'b1, 1, 32'h0, 1'b0, "rnd_write");
            end else if (r == 1) begin
                a = 32'h3080_0000 | ($urandom & 32'h007F_FFFF);
                xact(1'b0, a, 1'b0, 1'b1, 1, exp_stats(), 1'b0, "rnd_reg");
            end else if (r == 2) begin
                hb = 8'($urandom);
                if (hb == 8'h30) hb = 8'h31;
                a = {hb, 24'($urandom)};
                xact(i[0], a, 1'($urandom), 1'b0, 0, 32'h0, 1'b0, "rnd_miss");
            end else begin
                rand_ram_read(i[0], "rnd_read");
            end
        end
        xact(1'b0, 32'h3080_0004, 1'b0, 1'b1, 1, exp_stats(), 1'b0, "final_reg");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/marmot_wb_ram_reader.md
MARMOT_WB_RAM_READER -- requirements
Module: marmot_wb_ram_reader

Interface
REQ-001 SHALL have parameter NBANKS, default 8, number of SRAM macros on the shared read port (power of 2, 1..16).
REQ-002 SHALL have parameter AW, default 9, per-bank word address width.
REQ-003 SHALL have parameter DW, default 32, per-bank data width (32 or 64).
REQ-004 SHALL have parameter RD_LAT, default 1, SRAM port-1 read latency in clocks (1..4).
REQ-005 SHALL have parameter BASE_HI, default 8'h30, required value of wbs_adr_i[31:24] for a hit.
REQ-006 SHALL use one clock and synchronous active-high reset: wb_clk_i is the only clock; wb_rst_i is synchronous, active-high.
REQ-007 SHALL have ports wb_clk_i in 1 (clock); wb_rst_i in 1 (reset); wbs_stb_i in 1; wbs_cyc_i in 1; wbs_we_i in 1; wbs_sel_i in 4 (ignored); wbs_adr_i in 32; wbs_dat_i in 32 (ignored); wbs_ack_o out 1; wbs_dat_o out 32.
REQ-008 SHALL have ports ram_csb1 out NBANKS (active-low chip select per bank); ram_addr1 out AW (shared); ram_rdata1 in NBANKS*DW (bank b at [b*DW +: DW]).

Function
REQ-009 SHALL decode, with LW=log2(DW/32) and BW=log2(NBANKS): lane=adr[2 +: LW], word=adr[2+LW +: AW], bank=adr[2+LW+AW +: BW], reg_sel=adr[23]; adr[1:0] ignored.
REQ-010 SHALL treat a request as a hit only when wbs_stb_i & wbs_cyc_i & (adr[31:24]==BASE_HI); non-hits never produce ack.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK.
REQ-012 IDLE: on hit with reg_sel=0 and we=0, SHALL latch bank/word/lane and go to ISSUE; on hit with we=1 or reg_sel=1, SHALL go directly to ACK.
REQ-013 ISSUE (one cycle): ram_csb1[bank]=0, all other bits 1, ram_addr1=word; SHALL go to WAIT, loading a counter with RD_LAT-1.
REQ-014 WAIT: SHALL decrement the counter; when 0, SHALL capture ram_rdata1 slice (bank, lane) into the data register and go to ACK.
REQ-015 ACK: wbs_ack_o=1 for exactly one cycle if wbs_cyc_i is still high, else ack suppressed; SHALL return to IDLE.
REQ-016 Read latency SHALL be: request seen in IDLE at cycle T, csb1 low at T+1, ack at T+2+RD_LAT.
REQ-017 Writes to any hit address SHALL be acked one cycle after acceptance with no side effects.
REQ-018 wbs_dat_o SHALL hold the captured data while ack is high; 32'h0 otherwise.
REQ-019 ram_csb1 SHALL be all ones outside ISSUE; ram_addr1 SHALL hold its last value outside ISSUE.
REQ-020 A request arriving while not in IDLE SHALL be ignored until the FSM returns to IDLE; back-to-back reads SHALL be accepted in the cycle after ack.
REQ-021 Register-space reads (reg_sel=1) SHALL return the stats word per REQ-025/026.

Reset
REQ-022 On wb_rst_i=1 at a clock edge, SHALL set state=IDLE, wbs_ack_o=0, ram_csb1=all ones, ram_addr1=0, data register=0, stats counter=0.
REQ-023 Reset asserted mid-transaction SHALL abort it; no ack SHALL be issued for the aborted request.

Configuration
REQ-024 SHALL support macro MARMOT_RAMDBG_STATS_EN.
REQ-025 With MARMOT_RAMDBG_STATS_EN defined: SHALL keep a 32-bit counter of completed RAM reads (incremented in ACK for reads with reg_sel=0, wraps 0xFFFFFFFF->0); reg_sel=1 read SHALL return it.
REQ-026 Without MARMOT_RAMDBG_STATS_EN: no counter; reg_sel=1 read SHALL return 32'h0 with the same timing.

Verification
REQ-027 NBANKS=8, DW=32, RD_LAT=1: read adr 0x3000_0C10 (bank 3, word 4) with bank 3 rdata=0xA5A5_1234 -> csb1=8'b1111_0111, addr1=4 at T+1; ack at T+3 with dat 0xA5A5_1234.
REQ-028 DW=64, NBANKS=4: read lane 1 of bank 2 word 7, rdata=0x1111_2222_3333_4444 -> dat 0x1111_2222.
REQ-029 Write to 0x3000_0000 -> ack at T+1, csb1 stays 8'hFF, dat 0.
REQ-030 Read adr 0x4000_0000 -> no ack for 10 cycles, csb1 stays all ones.
REQ-031 wb_rst_i pulsed during WAIT with RD_LAT=3 -> no ack, csb1=all ones next cycle; following read completes normally.
REQ-032 STATS_EN: three RAM reads, then read 0x3080_0000 -> dat 3; without macro -> dat 0.
